xor_descrambler: RTL and testbench

Receive-side counterpart of the ALU XOR scrambling path: strips a keystream that the transmit side applied with the ALU XOR unit. It accepts scrambled DATA_W-bit beats over a valid/ready handshake and XORs each with the low bits of a 16-bit LFSR that advances once per accepted beat. Recovered beats go through a 2-entry output FIFO. A small start/stop FSM frames each session.

---
 rtl/xor_descrambler.sv | 148 ++++++++++++++
 tb/tb_xor_descrambler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_descrambler.sv
// xor_descrambler - strips an LFSR keystream from valid/ready beats into a 2-entry FIFO.
// Optional parity checking on the input beats is enabled by XOR_DESCR_PARITY_EN.
module xor_descrambler #(
  parameter int          DATA_W = 5,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
`ifdef XOR_DESCR_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic              accept;
  logic              pop;
  logic              lfsr_fb;
  logic [DATA_W-1:0] recovered;

  assign in_ready  = (state_q == ST_RUN) && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign recovered = in_data ^ lfsr_q[DATA_W-1:0];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          lfsr_d     = SEED;
          beat_cnt_d = 16'd0;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_q == 2'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Accept only happens in RUN, so it never collides with the IDLE reload.
    if (accept) begin
      lfsr_d     = {lfsr_q[14:0], lfsr_fb};
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  // Shift-style FIFO: head is always the output, so out_data is a plain flop.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (count_q)
      2'd0: begin
        if (accept) begin
          head_d  = recovered;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (accept && pop) begin
          head_d = recovered;
        end else if (accept) begin
          tail_d  = recovered;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      beat_cnt_q <= 16'd0;
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      beat_cnt_q <= beat_cnt_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign out_data = head_q;
  assign beat_cnt = beat_cnt_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef XOR_DESCR_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (state_q == ST_IDLE && start) par_err_d = 1'b0;
    if (accept && ((^in_data) != in_par)) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// tb_xor_descrambler - directed vector bench for xor_descrambler (SEED 16'hACE1, DATA_W 5).
module tb_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, in_valid, out_ready;
  logic [4:0]  in_data;
  logic        in_ready, out_valid, busy;
  logic [4:0]  out_data;
  logic [15:0] beat_cnt;
`ifdef XOR_DESCR_PARITY_EN
  logic        in_par;
  logic        par_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] din;
    logic [4:0] dout;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  xor_descrambler #(.DATA_W(5), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef XOR_DESCR_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Keystream low 5 bits from SEED ACE1: 01 03 07 0F 1E 1C 19 12 04 08 11
    vecs[0] = '{5'h00, 5'h01};
    vecs[1] = '{5'h00, 5'h03};
    vecs[2] = '{5'h1F, 5'h18};
    vecs[3] = '{5'h0A, 5'h05};
    vecs[4] = '{5'h1E, 5'h00};
    vecs[5] = '{5'h15, 5'h09};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_data = 5'h00; out_ready = 1'b0;
`ifdef XOR_DESCR_PARITY_EN
    in_par = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready",  {15'd0, in_ready},  16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data",  {11'd0, out_data},  16'd0);
    chk("rst_busy",      {15'd0, busy},      16'd0);
    chk("rst_beat_cnt",  beat_cnt,           16'd0);
`ifdef XOR_DESCR_PARITY_EN
    chk("rst_par_err",   {15'd0, par_err},   16'd0);
`endif

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_idle_busy", {15'd0, busy}, 16'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",     {15'd0, busy},     16'd1);
    chk("start_in_ready", {15'd0, in_ready}, 16'd1);
    chk("start_beat_cnt", beat_cnt,          16'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_out_valid", i), {15'd0, out_valid}, 16'd1);
      chk($sformatf("vec%0d_out_data", i),  {11'd0, out_data},  {11'd0, vecs[i].dout});
      chk($sformatf("vec%0d_beat_cnt", i),  beat_cnt,           16'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_out_valid", {15'd0, out_valid}, 16'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_ignored", beat_cnt, 16'd6);

    // Backpressure: two accepts fill the FIFO, the third beat waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h00;
    tick();
    chk("bp_ready_after_1", {15'd0, in_ready}, 16'd1);
    tick();
    chk("bp_ready_full",    {15'd0, in_ready}, 16'd0);
    chk("bp_head_full",     {11'd0, out_data}, 16'h0019);
    chk("bp_cnt_full",      beat_cnt,          16'd8);
    tick();
    chk("bp_held_ready",    {15'd0, in_ready}, 16'd0);
    chk("bp_held_cnt",      beat_cnt,          16'd8);
    out_ready = 1'b1;
    tick();
    chk("bp_second_out",    {11'd0, out_data}, 16'h0012);
    chk("bp_ready_again",   {15'd0, in_ready}, 16'd1);
    tick();
    chk("bp_third_out",     {11'd0, out_data}, 16'h0004);
    chk("bp_cnt_final",     beat_cnt,          16'd9);
    in_valid = 1'b0;
    tick();
    chk("bp_empty",         {15'd0, out_valid}, 16'd0);

    // Stop/drain, with the second beat accepted in the stop cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h00;
    tick();
    stop = 1'b1;
    tick();
    stop     = 1'b0;
    in_valid = 1'b0;
    chk("stop_in_ready",  {15'd0, in_ready}, 16'd0);
    chk("stop_busy",      {15'd0, busy},     16'd1);
    chk("stop_beat_cnt",  beat_cnt,          16'd11);
    chk("stop_head",      {11'd0, out_data}, 16'h0008);
    tick();
    chk("drain_hold_busy",  {15'd0, busy},      16'd1);
    chk("drain_hold_valid", {15'd0, out_valid}, 16'd1);
    chk("drain_hold_ready", {15'd0, in_ready},  16'd0);
    out_ready = 1'b1;
    tick();
    chk("drain_second_out", {11'd0, out_data},  16'h0011);
    chk("drain_busy_1",     {15'd0, busy},      16'd1);
    tick();
    chk("drain_empty",      {15'd0, out_valid}, 16'd0);
    chk("drain_busy_2",     {15'd0, busy},      16'd1);
    tick();
    chk("drain_idle_busy",  {15'd0, busy},      16'd0);

    // Restart with start and stop together, then reset mid-session.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("restart_busy", {15'd0, busy}, 16'd1);
    chk("restart_cnt",  beat_cnt,      16'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h00;
    tick();
    in_valid = 1'b0;
    chk("restart_first_out", {11'd0, out_data}, 16'h0001);
    chk("restart_valid",     {15'd0, out_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("async_rst_busy",      {15'd0, busy},      16'd0);
    chk("async_rst_cnt",       beat_cnt,           16'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef XOR_DESCR_PARITY_EN
    start = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 5'h03;
    in_par    = 1'b1;
    tick();
    chk("par_err_set",  {15'd0, par_err},  16'd1);
    chk("par_data_out", {11'd0, out_data}, 16'h0002);
    in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("par_err_sticky", {15'd0, par_err}, 16'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    chk("par_err_idle_kept", {15'd0, par_err}, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("par_err_cleared", {15'd0, par_err}, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
